moore_seq_gen: RTL and testbench

Serial pattern generator: captures a parallel pattern of up to WIDTH bits and emits it one bit per clock on a single serial line, MSB of the active portion first. It is the transmit-side counterpart to the team's serial sequence detectors and drives their `in_seq` input in benches and in the datapath. Control is a registered Moore FSM, so every output depends only on state registers.

---
 rtl/moore_seq_gen.sv | 136 +++++++++++++
 tb/tb_moore_seq_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/moore_seq_gen.sv
// rtl/moore_seq_gen.sv - Moore-FSM serial pattern generator, MSB of active portion first.
// Optional back-to-back frame repeat enabled by SEQ_GEN_REPEAT_EN.
module moore_seq_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             rep,
  output logic             out_seq,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;

`ifdef SEQ_GEN_REPEAT_EN
  logic [WIDTH-1:0] cap_shreg;
  logic [LEN_W-1:0] cap_cnt;
`else
  logic unused_rep;
  assign unused_rep = rep;
`endif

  // Left-align the active portion so the next bit is always shreg[WIDTH-1].
  always_comb begin
    eff_len = len;
    if (len == '0 || len > LEN_W'(WIDTH)) eff_len = LEN_W'(WIDTH);
    aligned = pattern << (LEN_W'(WIDTH) - eff_len);
  end

  // cnt holds the bits still to send after the one currently on out_seq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      out_seq <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      cap_shreg <= '0;
      cap_cnt   <= '0;
`endif
    end else if (abort) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      out_seq <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_seq <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (load) begin
            state   <= SEND;
            out_seq <= aligned[WIDTH-1];
            shreg   <= aligned << 1;
            cnt     <= eff_len - LEN_W'(1);
            valid   <= 1'b1;
            busy    <= 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
            cap_shreg <= aligned;
            cap_cnt   <= eff_len - LEN_W'(1);
`endif
          end
        end
        SEND: begin
          busy <= 1'b1;
          if (cnt != '0) begin
            out_seq <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            cnt     <= cnt - LEN_W'(1);
            valid   <= 1'b1;
            done    <= 1'b0;
          end else begin
`ifdef SEQ_GEN_REPEAT_EN
            if (rep) begin
              out_seq <= cap_shreg[WIDTH-1];
              shreg   <= cap_shreg << 1;
              cnt     <= cap_cnt;
              valid   <= 1'b1;
              done    <= 1'b0;
            end else
`endif
            begin
              state   <= DONE;
              out_seq <= 1'b0;
              valid   <= 1'b0;
              done    <= 1'b1;
              shreg   <= '0;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          out_seq <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          shreg   <= '0;
          cnt     <= '0;
          out_seq <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seq_gen.sv
// tb/tb_moore_seq_gen.sv - self-checking bench for moore_seq_gen with a bit-list reference model.
module tb_moore_seq_gen;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       abort;
  logic       rep;
  logic       out_seq;
  logic       valid;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SEQ_GEN_REPEAT_EN
  localparam int REP_EN = 1;
`else
  localparam int REP_EN = 0;
`endif

  moore_seq_gen #(.WIDTH(8), .LEN_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .pattern (pattern),
    .len     (len),
    .abort   (abort),
    .rep     (rep),
    .out_seq (out_seq),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_out, input logic e_valid,
                         input logic e_busy, input logic e_done);
    chk({tag, ".out_seq"}, out_seq, e_out);
    chk({tag, ".valid"},   valid,   e_valid);
    chk({tag, ".busy"},    busy,    e_busy);
    chk({tag, ".done"},    done,    e_done);
  endtask

  // Model: a frame is the L-bit tail of pat, highest bit first; repeats concatenate frames.
  task automatic run_frame(input string tag, input logic [7:0] pat, input logic [3:0] ln,
                           input int rep_frames);
    int eff, frames, total;
    logic [7:0] p;
    eff    = (ln == 0 || ln > 8) ? 8 : int'(ln);
    frames = (REP_EN != 0) ? rep_frames + 1 : 1;
    total  = eff * frames;
    p = pat;
    pattern = pat;
    len     = ln;
    load    = 1'b1;
    rep     = (rep_frames > 0);
    tick();
    load    = 1'b0;
    pattern = 8'($urandom);
    for (int i = 0; i < total; i++) begin
      chk_all($sformatf("%s.bit%0d", tag, i), p[eff - 1 - (i % eff)], 1'b1, 1'b1, 1'b0);
      rep = (i < rep_frames * eff);
      tick();
    end
    rep = 1'b0;
    chk_all({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    pattern = '0;
    len     = '0;
    abort   = 1'b0;
    rep     = 1'b0;
    @(negedge clk);
    chk_all("por", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame, away from any posedge.
    pattern = 8'hFF;
    len     = 4'd8;
    load    = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk_all("pre_reset_send", 1'b1, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("reset_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();
    chk_all("reset_release", 1'b0, 1'b0, 1'b0, 1'b0);

    run_frame("full", 8'b1011_0010, 4'd8, 0);
    run_frame("short3", 8'h05, 4'd3, 0);
    run_frame("len0", 8'($urandom), 4'd0, 0);
    run_frame("len12", 8'($urandom), 4'd12, 0);
    run_frame("len1", 8'($urandom), 4'd1, 0);

    // Loads during SEND and DONE must be ignored.
    pattern = 8'h0C;
    len     = 4'd4;
    load    = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("ign.bit%0d", i), (i < 2) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
      load    = (i == 1);
      pattern = (i == 1) ? 8'hFF : 8'h0C;
      tick();
    end
    load = 1'b0;
    chk_all("ign.done", 1'b0, 1'b0, 1'b1, 1'b1);
    pattern = 8'hFF;
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk_all("ign.idle0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("ign.idle1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort after the 3rd bit of 8'hAA.
    pattern = 8'hAA;
    len     = 4'd8;
    load    = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_all($sformatf("abort.bit%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk_all("abort.bit3", 1'b0, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("after_abort", 8'h96, 4'd8, 0);

    run_frame("repeat", 8'b0000_0001, 4'd3, 2);
    run_frame("repeat_one", 8'($urandom), 4'($urandom_range(1, 8)), 1);

    for (int n = 0; n < 8; n++) begin
      run_frame($sformatf("rand%0d", n), 8'($urandom), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
